obi_host_arbiter: RTL and testbench

//  2:1 OBI arbiter between the instruction-side (h0) and data-side (h1) host drivers and one memory port.

---
 rtl/obi_host_arbiter.sv | 167 ++++++++++++++++
 tb/tb_obi_host_arbiter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/obi_host_arbiter.sv
// 2:1 OBI host arbiter: round-robin with address-phase lock, plus in-order read-response
// routing through a small FIFO of host IDs. Request and response paths add no latency.
module obi_host_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int DEPTH  = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  h0_req_i,
    input  logic                  h0_we_i,
    input  logic [DATA_W/8-1:0]   h0_be_i,
    input  logic [ADDR_W-1:0]     h0_addr_i,
    input  logic [DATA_W-1:0]     h0_wdata_i,
    output logic                  h0_gnt_o,
    output logic                  h0_rvalid_o,
    output logic [DATA_W-1:0]     h0_rdata_o,
    input  logic                  h1_req_i,
    input  logic                  h1_we_i,
    input  logic [DATA_W/8-1:0]   h1_be_i,
    input  logic [ADDR_W-1:0]     h1_addr_i,
    input  logic [DATA_W-1:0]     h1_wdata_i,
    output logic                  h1_gnt_o,
    output logic                  h1_rvalid_o,
    output logic [DATA_W-1:0]     h1_rdata_o,
    output logic                  req_o,
    output logic                  we_o,
    output logic [DATA_W/8-1:0]   be_o,
    output logic [ADDR_W-1:0]     addr_o,
    output logic [DATA_W-1:0]     wdata_o,
    input  logic                  gnt_i,
    input  logic                  rvalid_i,
    input  logic [DATA_W-1:0]     rdata_i,
    output logic                  err_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic             lock_r;
    logic             lock_sel_r;
    logic             last_r;
    logic [DEPTH-1:0] fifo_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             err_r;

    logic             sel_s;
    logic             sel_req_s;
    logic             sel_we_s;
    logic             full_s;
    logic             empty_s;
    logic             req_s;
    logic             gnt_s;
    logic             push_s;
    logic             pop_s;
    logic             head_s;

    // Host selection, request mux and grant/response steering
    always_comb begin
        sel_s     = last_r;
        sel_req_s = 1'b0;
        sel_we_s  = 1'b0;
        we_o      = 1'b0;
        be_o      = '0;
        addr_o    = '0;
        wdata_o   = '0;

        if (lock_r) begin
            sel_s = lock_sel_r;
        end else if (h0_req_i && h1_req_i) begin
            sel_s = ~last_r;
        end else if (h1_req_i) begin
            sel_s = 1'b1;
        end else if (h0_req_i) begin
            sel_s = 1'b0;
        end else begin
            sel_s = last_r;
        end

        if (sel_s) begin
            sel_req_s = h1_req_i;
            sel_we_s  = h1_we_i;
            we_o      = h1_we_i;
            be_o      = h1_be_i;
            addr_o    = h1_addr_i;
            wdata_o   = h1_wdata_i;
        end else begin
            sel_req_s = h0_req_i;
            sel_we_s  = h0_we_i;
            we_o      = h0_we_i;
            be_o      = h0_be_i;
            addr_o    = h0_addr_i;
            wdata_o   = h0_wdata_i;
        end

        // A full ID FIFO only stalls reads; writes never need a response slot.
        full_s  = (count_r == CNT_W'(DEPTH));
        empty_s = (count_r == {CNT_W{1'b0}});
        req_s   = sel_req_s && !(full_s && !sel_we_s) && !rst_i;
        gnt_s   = req_s && gnt_i;
        push_s  = gnt_s && !sel_we_s;
        pop_s   = rvalid_i && !empty_s;
        head_s  = fifo_r[rd_ptr_r];

        req_o       = req_s;
        h0_gnt_o    = gnt_s && !sel_s;
        h1_gnt_o    = gnt_s && sel_s;
        h0_rvalid_o = pop_s && !head_s && !rst_i;
        h1_rvalid_o = pop_s && head_s && !rst_i;
        h0_rdata_o  = rdata_i;
        h1_rdata_o  = rdata_i;
        err_o       = err_r;
    end

    // Arbitration state: address-phase lock and round-robin history
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lock_r     <= 1'b0;
            lock_sel_r <= 1'b0;
            last_r     <= 1'b0;
        end else begin
            if (req_s && !gnt_i) begin
                lock_r     <= 1'b1;
                lock_sel_r <= sel_s;
            end else if (gnt_s) begin
                lock_r     <= 1'b0;
            end else begin
                lock_r     <= lock_r;
            end
            if (gnt_s) begin
                last_r <= sel_s;
            end else begin
                last_r <= last_r;
            end
        end
    end

    // Outstanding-read ID FIFO and sticky unexpected-response flag
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fifo_r   <= {DEPTH{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            err_r    <= 1'b0;
        end else begin
            if (push_s) begin
                fifo_r[wr_ptr_r] <= sel_s;
                wr_ptr_r         <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
            if (rvalid_i && empty_s) begin
                err_r <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_obi_host_arbiter.sv
// Directed bench for obi_host_arbiter: a queue-based reference model checked every
// falling edge, plus hand-computed literal checks for each scenario.
module tb_obi_host_arbiter;

    localparam int ADDR_W = 64;
    localparam int DATA_W = 64;
    localparam int DEPTH  = 2;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b1;
    logic              h0_req_i = 1'b0, h0_we_i = 1'b0;
    logic [7:0]        h0_be_i = 8'hFF;
    logic [63:0]       h0_addr_i = 64'h0, h0_wdata_i = 64'hA0A0_0000_0000_0000;
    logic              h0_gnt_o, h0_rvalid_o;
    logic [63:0]       h0_rdata_o;
    logic              h1_req_i = 1'b0, h1_we_i = 1'b0;
    logic [7:0]        h1_be_i = 8'h0F;
    logic [63:0]       h1_addr_i = 64'h0, h1_wdata_i = 64'hB1B1_0000_0000_0000;
    logic              h1_gnt_o, h1_rvalid_o;
    logic [63:0]       h1_rdata_o;
    logic              req_o, we_o;
    logic [7:0]        be_o;
    logic [63:0]       addr_o, wdata_o;
    logic              gnt_i = 1'b0, rvalid_i = 1'b0;
    logic [63:0]       rdata_i = 64'h0;
    logic              err_o;

    int checks = 0;
    int failures = 0;

    obi_host_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .h0_req_i(h0_req_i), .h0_we_i(h0_we_i), .h0_be_i(h0_be_i), .h0_addr_i(h0_addr_i),
        .h0_wdata_i(h0_wdata_i), .h0_gnt_o(h0_gnt_o), .h0_rvalid_o(h0_rvalid_o), .h0_rdata_o(h0_rdata_o),
        .h1_req_i(h1_req_i), .h1_we_i(h1_we_i), .h1_be_i(h1_be_i), .h1_addr_i(h1_addr_i),
        .h1_wdata_i(h1_wdata_i), .h1_gnt_o(h1_gnt_o), .h1_rvalid_o(h1_rvalid_o), .h1_rdata_o(h1_rdata_o),
        .req_o(req_o), .we_o(we_o), .be_o(be_o), .addr_o(addr_o), .wdata_o(wdata_o),
        .gnt_i(gnt_i), .rvalid_i(rvalid_i), .rdata_i(rdata_i), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: outstanding reads as a queue of host IDs
    bit m_q[$];
    bit m_locked = 1'b0, m_lock_host = 1'b0, m_last = 1'b0, m_err = 1'b0;

    always @(negedge clk_i) begin
        bit sel, w, r, ereq, egnt;
        if (rst_i) begin
            chk("m_rst_req", req_o, 64'd0);
            chk("m_rst_gnt", {h1_gnt_o, h0_gnt_o}, 64'd0);
            chk("m_rst_rvalid", {h1_rvalid_o, h0_rvalid_o}, 64'd0);
            chk("m_rst_err", err_o, 64'd0);
            m_q.delete();
            m_locked = 1'b0; m_lock_host = 1'b0; m_last = 1'b0; m_err = 1'b0;
        end else begin
            if (m_locked) sel = m_lock_host;
            else if (h0_req_i && h1_req_i) sel = !m_last;
            else if (h0_req_i) sel = 1'b0;
            else if (h1_req_i) sel = 1'b1;
            else sel = m_last;
            r = sel ? h1_req_i : h0_req_i;
            w = sel ? h1_we_i : h0_we_i;
            ereq = r && !(m_q.size() == DEPTH && !w);
            egnt = ereq && gnt_i;
            chk("m_req", req_o, ereq);
            chk("m_gnt0", h0_gnt_o, egnt && !sel);
            chk("m_gnt1", h1_gnt_o, egnt && sel);
            if (ereq) begin
                chk("m_addr", addr_o, sel ? h1_addr_i : h0_addr_i);
                chk("m_we", we_o, w);
                chk("m_be", be_o, sel ? h1_be_i : h0_be_i);
                chk("m_wdata", wdata_o, sel ? h1_wdata_i : h0_wdata_i);
            end
            chk("m_rv0", h0_rvalid_o, rvalid_i && m_q.size() != 0 && m_q[0] == 1'b0);
            chk("m_rv1", h1_rvalid_o, rvalid_i && m_q.size() != 0 && m_q[0] == 1'b1);
            chk("m_rdata0", h0_rdata_o, rdata_i);
            chk("m_rdata1", h1_rdata_o, rdata_i);
            chk("m_err", err_o, m_err);
            if (rvalid_i && m_q.size() == 0) m_err = 1'b1;
            if (rvalid_i && m_q.size() != 0) void'(m_q.pop_front());
            if (egnt && !w) m_q.push_back(sel);
            if (ereq && !gnt_i) begin
                m_locked = 1'b1; m_lock_host = sel;
            end else if (egnt) begin
                m_locked = 1'b0;
            end
            if (egnt) m_last = sel;
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic host(input bit n, input bit req, input bit we, input logic [63:0] addr);
        if (n) begin h1_req_i = req; h1_we_i = we; h1_addr_i = addr; end
        else   begin h0_req_i = req; h0_we_i = we; h0_addr_i = addr; end
    endtask

    task automatic resp(input bit v, input logic [63:0] d);
        rvalid_i = v; rdata_i = d;
    endtask

    initial begin
        #2;
        chk("rst_req", req_o, 64'd0);
        chk("rst_err", err_o, 64'd0);
        tick(); tick();
        rst_i = 1'b0;

        // 1: single h1 read, response next cycle
        tick(); host(1'b1, 1'b1, 1'b0, 64'h1000); gnt_i = 1'b1;
        #2 chk("t1_gnt1", h1_gnt_o, 64'd1); chk("t1_addr", addr_o, 64'h1000);
        tick(); host(1'b1, 1'b0, 1'b0, 64'h0); gnt_i = 1'b0; resp(1'b1, 64'hDEAD);
        #2 chk("t1_rv1", h1_rvalid_o, 64'd1); chk("t1_rv0", h0_rvalid_o, 64'd0);
        chk("t1_rdata", h1_rdata_o, 64'hDEAD);

        // 2: both read with last=h1 -> h0 first, then h1; responses routed in order
        tick(); resp(1'b0, 64'h0);
        host(1'b0, 1'b1, 1'b0, 64'h2000); host(1'b1, 1'b1, 1'b0, 64'h3000); gnt_i = 1'b1;
        #2 chk("t2_gnt0", h0_gnt_o, 64'd1); chk("t2_addr0", addr_o, 64'h2000);
        tick(); host(1'b0, 1'b0, 1'b0, 64'h0);
        #2 chk("t2_gnt1", h1_gnt_o, 64'd1); chk("t2_addr1", addr_o, 64'h3000);
        tick(); host(1'b1, 1'b0, 1'b0, 64'h0); gnt_i = 1'b0; resp(1'b1, 64'h11);
        #2 chk("t2_rv0", h0_rvalid_o, 64'd1); chk("t2_rv0_other", h1_rvalid_o, 64'd0);
        tick(); resp(1'b1, 64'h22);
        #2 chk("t2_rv1", h1_rvalid_o, 64'd1); chk("t2_rv1_other", h0_rvalid_o, 64'd0);

        // 3: h0 held off by gnt_i=0 while h1 waits; address stays locked to h0
        tick(); resp(1'b0, 64'h0);
        host(1'b0, 1'b1, 1'b0, 64'h4000); host(1'b1, 1'b1, 1'b0, 64'h5000);
        for (int i = 0; i < 3; i++) begin
            #2 chk("t3_addr_hold", addr_o, 64'h4000); chk("t3_no_gnt", h0_gnt_o, 64'd0);
            tick();
        end
        gnt_i = 1'b1;
        #2 chk("t3_gnt0", h0_gnt_o, 64'd1); chk("t3_addr", addr_o, 64'h4000);
        tick(); host(1'b0, 1'b0, 1'b0, 64'h0);
        #2 chk("t3_gnt1", h1_gnt_o, 64'd1); chk("t3_addr1", addr_o, 64'h5000);
        tick(); host(1'b1, 1'b0, 1'b0, 64'h0); gnt_i = 1'b0; resp(1'b1, 64'h33);
        tick(); resp(1'b1, 64'h44);
        tick(); resp(1'b0, 64'h0);

        // 4: FIFO full blocks h0 read, h1 write still passes, pop frees a slot next cycle
        host(1'b0, 1'b1, 1'b0, 64'h6000); gnt_i = 1'b1;
        tick(); host(1'b0, 1'b1, 1'b0, 64'h6008);
        tick(); host(1'b0, 1'b1, 1'b0, 64'h6010);
        #2 chk("t4_blocked", req_o, 64'd0); chk("t4_no_gnt0", h0_gnt_o, 64'd0);
        tick(); host(1'b1, 1'b1, 1'b1, 64'h7000);
        #2 chk("t4_wr_gnt1", h1_gnt_o, 64'd1); chk("t4_wr_we", we_o, 64'd1);
        tick(); host(1'b1, 1'b0, 1'b0, 64'h0); resp(1'b1, 64'h55);
        #2 chk("t4_still_full", req_o, 64'd0); chk("t4_rv0", h0_rvalid_o, 64'd1);
        tick(); resp(1'b0, 64'h0);
        #2 chk("t4_accept", h0_gnt_o, 64'd1); chk("t4_addr", addr_o, 64'h6010);
        tick(); host(1'b0, 1'b0, 1'b0, 64'h0); gnt_i = 1'b0; resp(1'b1, 64'h66);
        tick(); resp(1'b1, 64'h77);

        // 5: spurious response with nothing outstanding
        tick(); resp(1'b1, 64'h88);
        #2 chk("t5_rv", {h1_rvalid_o, h0_rvalid_o}, 64'd0);
        tick(); resp(1'b0, 64'h0);
        #2 chk("t5_err", err_o, 64'd1);
        tick(); tick();
        #2 chk("t5_err_sticky", err_o, 64'd1);

        // 6: async reset while h0 is locked with one h1 read outstanding
        tick(); host(1'b1, 1'b1, 1'b0, 64'h8000); gnt_i = 1'b1;
        tick(); host(1'b1, 1'b0, 1'b0, 64'h0); host(1'b0, 1'b1, 1'b0, 64'h9000); gnt_i = 1'b0;
        tick();
        #2 rst_i = 1'b1; resp(1'b1, 64'h99);
        #1 chk("t6_req", req_o, 64'd0); chk("t6_gnt", {h1_gnt_o, h0_gnt_o}, 64'd0);
        chk("t6_rv", {h1_rvalid_o, h0_rvalid_o}, 64'd0); chk("t6_err", err_o, 64'd0);
        tick(); rst_i = 1'b0; resp(1'b0, 64'h0);
        host(1'b0, 1'b0, 1'b0, 64'h0); host(1'b1, 1'b1, 1'b0, 64'hA000);
        #2 chk("t6_unlocked", req_o, 64'd1); chk("t6_addr", addr_o, 64'hA000);
        tick(); host(1'b1, 1'b0, 1'b0, 64'h0); resp(1'b1, 64'hAA);
        #2 chk("t6_empty_rv", {h1_rvalid_o, h0_rvalid_o}, 64'd0);
        tick(); resp(1'b0, 64'h0);
        #2 chk("t6_empty_err", err_o, 64'd1);
        tick(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
